// File: rtl/sample_rle_encoder.sv
// sample_rle_encoder
//   Run-length compressor between the sample serializer and the stream sink.
//   Raw samples are emitted as-is; two equal raw words in a row mean "a run
//   count follows". The count word is the number of further equal samples.
//   An all-ones count word marks a full run segment and the run continues.
//   Every 2^PAGE_LOG accepted samples a new page starts, so a decoder can
//   resynchronise there. The first word of each page carries out_new_page=1.
//   The serializer cannot stall. A sample offered while in_ready is low is
//   lost, and this sets the sticky overflow_error flag.
//
// Optional feature macro: SAMPLE_RLE_STATS_EN
//   Adds the 40-bit counters stat_in_count (accepted samples) and
//   stat_out_words (popped words).
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   clear           one-cycle flush/restart, same effect as reset
//   in_data/in_valid/in_ready   sample input (see handshake note below)
//   out_data/out_new_page/out_valid/out_ready   output FIFO head
//   overflow_error  sticky: a sample was dropped
//
// Handshake: a transfer happens on a clock edge where valid && ready.
//   Output: out_data/out_new_page stay stable while out_valid && !out_ready.
//   Input: in_valid is not held back by in_ready. A sample offered while
//   in_ready is low is dropped, unless clear is asserted in the same cycle.
module sample_rle_encoder #(
    parameter int DW         = 16,
    parameter int PAGE_LOG   = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_new_page,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef SAMPLE_RLE_STATS_EN
    output logic [39:0]   stat_in_count,
    output logic [39:0]   stat_out_words,
`endif
    output logic          overflow_error
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [DW-1:0] ALL_ONES   = '1;
    localparam logic [DW-1:0] CNTR_LAST  = {{(DW-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {ST_INIT, ST_SINGLE, ST_RUN, ST_RECOVER} state_t;

    state_t                state_q, state_d;
    logic [PAGE_LOG-1:0]   page_q, page_d;
    logic [DW-1:0]         cntr_q, cntr_d;
    logic [DW-1:0]         last_q, last_d;
    logic                  rec_np_q, rec_np_d;
    logic                  ovf_q, ovf_d;
    logic [DW:0]           mem_q [FIFO_DEPTH];
    logic [DW:0]           mem_d [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
`ifdef SAMPLE_RLE_STATS_EN
    logic [39:0]           stat_in_q, stat_in_d;
    logic [39:0]           stat_out_q, stat_out_d;
`endif

    logic [AW:0] free_w;
    logic        accept, pop, push, page_start, same;
    logic [DW:0] push_word;

    // The two-free-entries rule leaves room for the extra word that
    // RECOVER always pushes right after a run is terminated.
    assign free_w     = (AW+1)'(FIFO_DEPTH) - count_q;
    assign in_ready   = (state_q != ST_RECOVER) && (free_w >= (AW+1)'(2));
    assign accept     = in_valid && in_ready;
    assign page_start = (page_q == '0);
    assign same       = (in_data == last_q);

    assign out_valid      = (count_q != '0);
    assign pop            = out_valid && out_ready;
    assign out_data       = mem_q[rd_ptr_q][DW-1:0];
    assign out_new_page   = mem_q[rd_ptr_q][DW];
    assign overflow_error = ovf_q;

    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        cntr_d    = cntr_q;
        last_d    = last_q;
        rec_np_d  = rec_np_q;
        ovf_d     = ovf_q;
        push      = 1'b0;
        push_word = '0;

        case (state_q)
            ST_INIT: begin
                if (accept) begin
                    push      = 1'b1;
                    push_word = {1'b1, in_data};
                    state_d   = ST_SINGLE;
                end
            end
            ST_SINGLE: begin
                if (accept) begin
                    push = 1'b1;
                    if (page_start) begin
                        push_word = {1'b1, in_data};
                    end else if (!same) begin
                        push_word = {1'b0, in_data};
                    end else begin
                        // Second equal raw word: a count word will follow.
                        push_word = {1'b0, in_data};
                        cntr_d    = '0;
                        state_d   = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (page_start || !same) begin
                        // Close the run. The new sample is emitted raw in
                        // RECOVER, from last_q, which is updated below.
                        push      = 1'b1;
                        push_word = {1'b0, cntr_q};
                        rec_np_d  = page_start;
                        state_d   = ST_RECOVER;
                    end else if (cntr_q == CNTR_LAST) begin
                        push      = 1'b1;
                        push_word = {1'b0, ALL_ONES};
                        cntr_d    = '0;
                    end else begin
                        cntr_d = cntr_q + 1'b1;
                    end
                end
            end
            ST_RECOVER: begin
                push      = 1'b1;
                push_word = {rec_np_q, last_q};
                state_d   = ST_SINGLE;
            end
            default: state_d = ST_INIT;
        endcase

        if (accept) begin
            last_d = in_data;
            page_d = page_q + 1'b1;
        end
        if (in_valid && !in_ready) begin
            ovf_d = 1'b1;
        end

        // FIFO bookkeeping
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_word;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

`ifdef SAMPLE_RLE_STATS_EN
        stat_in_d  = stat_in_q + (accept ? 40'd1 : 40'd0);
        stat_out_d = stat_out_q + (pop ? 40'd1 : 40'd0);
`endif

        // clear wins over everything, including a sample in the same cycle.
        if (clear) begin
            state_d  = ST_INIT;
            page_d   = '0;
            cntr_d   = '0;
            rec_np_d = 1'b0;
            ovf_d    = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
`ifdef SAMPLE_RLE_STATS_EN
            stat_in_d  = '0;
            stat_out_d = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            page_q   <= '0;
            cntr_q   <= '0;
            last_q   <= '0;
            rec_np_q <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
`ifdef SAMPLE_RLE_STATS_EN
            stat_in_q  <= '0;
            stat_out_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            cntr_q   <= cntr_d;
            last_q   <= last_d;
            rec_np_q <= rec_np_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
`ifdef SAMPLE_RLE_STATS_EN
            stat_in_q  <= stat_in_d;
            stat_out_q <= stat_out_d;
`endif
        end
    end

    // Storage needs no reset: entries are only read once count_q covers them.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef SAMPLE_RLE_STATS_EN
    assign stat_in_count  = stat_in_q;
    assign stat_out_words = stat_out_q;
`endif

endmodule

// File: tb/tb_sample_rle_encoder.sv
module tb_sample_rle_encoder;
    localparam int DW         = 8;
    localparam int PAGE_LOG   = 9;
    localparam int FIFO_DEPTH = 4;
    localparam int PAGE_LEN   = 1 << PAGE_LOG;
    localparam int SEG        = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst_n, clear, in_valid, in_ready;
    logic [DW-1:0] in_data, out_data;
    logic          out_new_page, out_valid, out_ready, overflow_error;
`ifdef SAMPLE_RLE_STATS_EN
    logic [39:0]   stat_in_count, stat_out_words;
`endif

    sample_rle_encoder #(.DW(DW), .PAGE_LOG(PAGE_LOG), .FIFO_DEPTH(FIFO_DEPTH)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_new_page   (out_new_page),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
`ifdef SAMPLE_RLE_STATS_EN
        .stat_in_count  (stat_in_count),
        .stat_out_words (stat_out_words),
`endif
        .overflow_error (overflow_error)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // exp_q mirrors the expected FIFO contents: {new_page, word}.
    logic [DW:0]   exp_q[$];
    int            m_page;
    int            m_run_len;
    logic [DW-1:0] m_run_val;
    bit            m_pend;
    logic [DW:0]   m_pend_word;
    bit            m_ovf;
    longint        m_stat_in, m_stat_out;

    function automatic void model_reset();
        exp_q.delete();
        m_page     = 0;
        m_run_len  = 0;
        m_run_val  = '0;
        m_pend     = 0;
        m_pend_word = '0;
        m_ovf      = 0;
        m_stat_in  = 0;
        m_stat_out = 0;
    endfunction

    // A word that follows a closed run lands one cycle later; until then
    // the encoder refuses input.
    function automatic bit exp_ready();
        return !m_pend && ((FIFO_DEPTH - exp_q.size()) >= 2);
    endfunction

    // Run-length rules per page: a run of L equal samples encodes as
    // v, or v v {SEG marker per full 255}... (L-2) mod SEG.
    function automatic void model_accept(input logic [DW-1:0] s);
        bit ps;
        logic [DW-1:0] cw;
        ps = (m_page == 0);
        if (ps || m_run_len == 0 || s != m_run_val) begin
            if (m_run_len >= 2) begin
                cw = DW'((m_run_len - 2) % SEG);
                exp_q.push_back({1'b0, cw});
                m_pend      = 1;
                m_pend_word = {ps, s};
            end else begin
                exp_q.push_back({ps, s});
            end
            m_run_val = s;
            m_run_len = 1;
        end else begin
            m_run_len++;
            if (m_run_len == 2) begin
                exp_q.push_back({1'b0, s});
            end else if (((m_run_len - 2) % SEG) == 0) begin
                exp_q.push_back({1'b0, {DW{1'b1}}});
            end
        end
        m_page = (m_page + 1) % PAGE_LEN;
    endfunction

    function automatic void model_edge(input logic v, input logic [DW-1:0] d,
                                       input logic ordy, input logic clr, input bit rdy);
        bit do_pop;
        if (clr) begin
            model_reset();
            return;
        end
        do_pop = ordy && (exp_q.size() != 0);
        if (m_pend) begin
            exp_q.push_back(m_pend_word);
            m_pend = 0;
        end
        if (v) begin
            if (rdy) begin
                model_accept(d);
                m_stat_in++;
            end else begin
                m_ovf = 1;
            end
        end
        if (do_pop) begin
            void'(exp_q.pop_front());
            m_stat_out++;
        end
    endfunction

    // ---------------- driver tasks ----------------
    // Called just after a falling edge; checks the current outputs, then
    // advances one clock and updates the model.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic ordy, input logic clr);
        bit rdy;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        clear     = clr;
        rdy = exp_ready();
        check("in_ready", in_ready, rdy);
        check("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("out_data", out_data, exp_q[0][DW-1:0]);
            check("out_new_page", out_new_page, exp_q[0][DW]);
        end
        check("overflow_error", overflow_error, m_ovf);
`ifdef SAMPLE_RLE_STATS_EN
        check("stat_in_count", stat_in_count, m_stat_in[39:0]);
        check("stat_out_words", stat_out_words, m_stat_out[39:0]);
`endif
        @(posedge clk);
        model_edge(v, d, ordy, clr, rdy);
        @(negedge clk);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic ordy);
        bit done;
        done = 0;
        for (int i = 0; i < 8 && !done; i++) begin
            if (exp_ready()) begin
                step(1'b1, d, ordy, 1'b0);
                done = 1;
            end else begin
                step(1'b0, '0, ordy, 1'b0);
            end
        end
        check("send_accepted", done, 1'b1);
    endtask

    task automatic pulse_reset(input logic v, input logic [DW-1:0] d);
        in_valid  = v;
        in_data   = d;
        out_ready = 1'b1;
        clear     = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        pulse_reset(1'b0, '0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_overflow", overflow_error, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);

        // Distinct samples: raw, first one opens the page.
        send(8'h11, 1'b1); send(8'h22, 1'b1); send(8'h33, 1'b1);
        drain(6);

        // Short run terminated by a new value.
        step(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) send(8'hAA, 1'b1);
        send(8'h55, 1'b1);
        drain(6);

        // Run long enough for one full segment marker.
        step(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 257; i++) send(8'h5A, 1'b1);
        send(8'h01, 1'b1);
        drain(6);

        // Run crossing a page boundary.
        step(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < PAGE_LEN + 8; i++) send(8'h07, 1'b1);
        send(8'h09, 1'b1);
        drain(6);

        // Backpressure and drop detection, then clear.
        step(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        check("drop_overflow_set", overflow_error, 1'b1);
        check("drop_in_ready_low", in_ready, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        check("clear_out_valid", out_valid, 1'b0);
        check("clear_overflow", overflow_error, 1'b0);
        drain(2);

        // Clear wins over a same-cycle sample.
        step(1'b1, 8'h77, 1'b1, 1'b1);
        check("clear_discards", out_valid, 1'b0);
        drain(2);

        // Reset mid-run with in_valid held high.
        for (int i = 0; i < 6; i++) send(8'h66, 1'b1);
        pulse_reset(1'b1, 8'h66);
        check("midrun_reset_out_valid", out_valid, 1'b0);
        send(8'h34, 1'b1);
        drain(6);

        // Random traffic, upstream honouring in_ready.
        for (int i = 0; i < 1500; i++) begin
            logic v;
            v = ($urandom_range(0, 99) < 75) && exp_ready();
            step(v, 8'($urandom_range(0, 2)), $urandom_range(0, 99) < 60,
                 $urandom_range(0, 299) == 0);
        end
        drain(8);

        // Random traffic with drops allowed and occasional long runs.
        for (int i = 0; i < 1500; i++) begin
            logic [DW-1:0] d;
            d = ($urandom_range(0, 9) < 8) ? 8'hC3 : 8'($urandom_range(0, 255));
            step($urandom_range(0, 99) < 70, d, $urandom_range(0, 99) < 80,
                 $urandom_range(0, 399) == 0);
        end
        drain(8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
